// File: rtl/product_accumulator.sv
// Accumulates N_TERMS unsigned 32-bit products over a valid/ready stream and
// returns the 32-bit saturated total with an overflow flag on a second handshake.
module product_accumulator #(
   parameter int unsigned N_TERMS = 8,
   parameter int unsigned ACC_W   = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] p_in,
   input  logic        p_valid,
   output logic        p_ready,
   output logic [31:0] sum,
   output logic        ovf,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy
);

   localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
   localparam logic [ACC_W-1:0] MAX32 = ACC_W'(64'h0000_0000_FFFF_FFFF);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      sum_q, sum_d;
   logic             ovf_q, ovf_d;
   logic             p_ready_q, out_valid_q, busy_q;
   logic [ACC_W-1:0] total;
   logic             take;

   assign total = acc_q + ACC_W'(p_in);
   // p_ready_q is high exactly while in ACCUM, so it doubles as the handshake qualifier
   assign take  = p_valid & p_ready_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         ACCUM: begin
            if (take) begin
               acc_d = total;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  state_d = DONE;
                  ovf_d   = (total > MAX32);
                  sum_d   = (total > MAX32) ? '1 : total[31:0];
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so every output is a flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         ovf_q       <= 1'b0;
         p_ready_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         ovf_q       <= ovf_d;
         p_ready_q   <= (state_d == ACCUM);
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d != IDLE);
      end
   end

   assign p_ready   = p_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign sum       = sum_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed and randomized checks of product_accumulator (N_TERMS=8 and N_TERMS=1)
// against a plain-arithmetic reference of the saturated sum.
module tb_product_accumulator;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] p_in = '0;
   logic        p_valid = 1'b0;
   logic        p_ready;
   logic [31:0] sum;
   logic        ovf;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy;

   logic        start1 = 1'b0;
   logic [31:0] p_in1 = '0;
   logic        p_valid1 = 1'b0;
   logic        p_ready1;
   logic [31:0] sum1;
   logic        ovf1;
   logic        out_valid1;
   logic        out_ready1 = 1'b0;
   logic        busy1;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] prods [N];

   always #5 clk = ~clk;

   product_accumulator #(.N_TERMS(8), .ACC_W(40)) dut (
      .clk(clk), .rst(rst), .start(start), .p_in(p_in), .p_valid(p_valid),
      .p_ready(p_ready), .sum(sum), .ovf(ovf), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy)
   );

   product_accumulator #(.N_TERMS(1), .ACC_W(32)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .p_in(p_in1), .p_valid(p_valid1),
      .p_ready(p_ready1), .sum(sum1), .ovf(ovf1), .out_valid(out_valid1),
      .out_ready(out_ready1), .busy(busy1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // gap_mode: 0 = p_valid always high, 1 = pattern 1,0,0,..., 2 = random.
   task automatic run_op(input string tag, input int gap_mode, input bit start_hold,
                         input int hold);
      longint unsigned tot;
      logic [31:0] exp_sum;
      logic        exp_ovf;
      logic        hs;
      int          idx;
      int          cyc;
      tot = 0;
      for (int i = 0; i < N; i++) tot += 64'(prods[i]);
      exp_ovf = (tot > 64'h0000_0000_FFFF_FFFF);
      exp_sum = exp_ovf ? 32'hFFFF_FFFF : tot[31:0];

      start = 1'b1;
      tick();
      if (!start_hold) start = 1'b0;
      chk1({tag, "_p_ready_after_start"}, p_ready, 1'b1);
      chk1({tag, "_busy_after_start"}, busy, 1'b1);

      idx = 0;
      cyc = 0;
      while (idx < N && cyc < 200) begin
         case (gap_mode)
            0:       p_valid = 1'b1;
            1:       p_valid = (cyc % 3 == 0);
            default: p_valid = 1'($urandom_range(0, 1));
         endcase
         p_in = p_valid ? prods[idx] : $urandom;
         hs = p_valid && p_ready;
         tick();
         cyc++;
         if (hs) idx++;
         if (idx < N) chk1({tag, "_no_early_out_valid"}, out_valid, 1'b0);
      end
      p_valid = 1'b0;
      if (idx < N) chk32({tag, "_timeout_products_accepted"}, 32'(idx), 32'(N));

      chk1({tag, "_out_valid"}, out_valid, 1'b1);
      chk1({tag, "_p_ready_low_in_done"}, p_ready, 1'b0);
      chk1({tag, "_busy_in_done"}, busy, 1'b1);
      chk32({tag, "_sum"}, sum, exp_sum);
      chk1({tag, "_ovf"}, ovf, exp_ovf);

      for (int h = 0; h < hold; h++) begin
         tick();
         chk1({tag, "_out_valid_held"}, out_valid, 1'b1);
         chk32({tag, "_sum_held"}, sum, exp_sum);
      end

      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      start = 1'b0;
      chk1({tag, "_out_valid_cleared"}, out_valid, 1'b0);
      chk1({tag, "_idle_after_consume"}, busy, 1'b0);
      chk1({tag, "_p_ready_idle"}, p_ready, 1'b0);
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      chk1("reset_p_ready", p_ready, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_out_valid", out_valid, 1'b0);
      chk32("reset_sum", sum, 32'd0);
      chk1("reset_ovf", ovf, 1'b0);

      for (int i = 0; i < N; i++) prods[i] = 32'(i + 1);
      run_op("basic", 0, 1'b0, 0);

      for (int i = 0; i < N; i++) prods[i] = 32'hFFFE_0001;
      run_op("saturate", 0, 1'b0, 1);

      for (int i = 0; i < N; i++) prods[i] = 32'(i + 1);
      run_op("stall", 1, 1'b0, 5);

      for (int i = 0; i < N; i++) prods[i] = 32'(3 * i + 7);
      run_op("start_ignored", 2, 1'b1, 2);

      // Reset mid-operation after three accepted products.
      start = 1'b1;
      tick();
      start = 1'b0;
      p_valid = 1'b1;
      p_in = 32'd1000;
      for (int i = 0; i < 3; i++) tick();
      p_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("midrst_p_ready", p_ready, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk32("midrst_sum", sum, 32'd0);
      chk1("midrst_ovf", ovf, 1'b0);
      for (int i = 0; i < N; i++) prods[i] = 32'd10;
      run_op("after_reset", 0, 1'b0, 0);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
               0:       prods[i] = 32'($urandom_range(0, 65535));
               1:       prods[i] = $urandom;
               default: prods[i] = 32'hFFFF_FFFF - 32'($urandom_range(0, 255));
            endcase
         end
         run_op("random", 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      // Single-term build: the first accepted product completes the operation.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk1("n1_p_ready", p_ready1, 1'b1);
      p_valid1 = 1'b1;
      p_in1 = 32'h1234;
      tick();
      p_valid1 = 1'b0;
      chk1("n1_out_valid", out_valid1, 1'b1);
      chk32("n1_sum", sum1, 32'h1234);
      chk1("n1_ovf", ovf1, 1'b0);
      out_ready1 = 1'b1;
      tick();
      out_ready1 = 1'b0;
      chk1("n1_idle", busy1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
